// File: rtl/cvxif_copro_responder.sv
// rtl/cvxif_copro_responder.sv - CV-X-IF coprocessor responder: custom-0 decode, in-order op queue, result channel
// Optional feature macro: CVXIF_COPRO_MUL_EN (enables the MUL op with a MUL_LAT countdown)
module cvxif_copro_responder #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned ID_WIDTH = 3,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MUL_LAT  = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [31:0]         issue_instr_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  logic [XLEN-1:0]     issue_rs1_i,
   input  logic [XLEN-1:0]     issue_rs2_i,
   output logic                issue_accept_o,
   output logic                issue_writeback_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [4:0]          result_rd_o,
   output logic [XLEN-1:0]     result_data_o,
   output logic                result_we_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
   localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;

   logic [ID_WIDTH-1:0] id_q   [DEPTH];
   logic [4:0]          rd_q   [DEPTH];
   logic [XLEN-1:0]     data_q [DEPTH];
   logic                we_q   [DEPTH];
   logic [CNT_W-1:0]    cnt_q  [DEPTH];
   logic                cmt_q  [DEPTH];
   logic                kill_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             dec_legal, dec_wb, issue_hs, push, pop;
   logic             head_live, head_ready, head_drop;
   logic [XLEN-1:0]  dec_result;
   logic [CNT_W-1:0] dec_cnt;
   logic             unused_instr_bits;

   // rs1/rs2 register specifiers arrive as operand values, so their fields are not needed
   assign unused_instr_bits = ^issue_instr_i[24:15];

   assign issue_ready_o = (count_q < (PTR_W+1)'(DEPTH));
   assign issue_hs      = issue_valid_i & issue_ready_o;

   // Decode the offered instruction and compute its result at issue time
   always_comb begin
      dec_legal  = 1'b0;
      dec_wb     = 1'b0;
      dec_result = '0;
      dec_cnt    = '0;
      if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == 7'd0) begin
         case (issue_instr_i[14:12])
            3'b000: begin
               dec_legal  = 1'b1;
               dec_wb     = 1'b1;
               dec_result = issue_rs1_i + issue_rs2_i;
            end
            3'b001: begin
               dec_legal  = 1'b1;
               dec_wb     = 1'b1;
               dec_result = issue_rs1_i ^ issue_rs2_i;
            end
`ifdef CVXIF_COPRO_MUL_EN
            3'b010: begin
               dec_legal  = 1'b1;
               dec_wb     = 1'b1;
               dec_result = issue_rs1_i * issue_rs2_i;
               dec_cnt    = CNT_W'(MUL_LAT - 1);
            end
`endif
            3'b011: begin
               dec_legal  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign issue_accept_o    = issue_hs & dec_legal;
   assign issue_writeback_o = issue_hs & dec_wb;
   assign push              = issue_accept_o;

   assign head_live  = (count_q != '0);
   assign head_drop  = head_live & kill_q[head_q];
   assign head_ready = head_live & cmt_q[head_q] & ~kill_q[head_q] & (cnt_q[head_q] == '0);
   assign pop        = head_drop | (head_ready & result_ready_i);

   // Result channel presents the head entry straight from the queue flops
   assign result_valid_o = head_ready;
   assign result_id_o    = head_ready ? id_q[head_q]   : '0;
   assign result_rd_o    = head_ready ? rd_q[head_q]   : '0;
   assign result_data_o  = head_ready ? data_q[head_q] : '0;
   assign result_we_o    = head_ready ? we_q[head_q]   : 1'b0;

   // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two
   always_comb begin
      head_d  = pop  ? head_q + 1'b1 : head_q;
      tail_d  = push ? tail_q + 1'b1 : tail_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage: countdown ageing, commit/kill marking, and writing the newly accepted op
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i]   <= '0;
            rd_q[i]   <= '0;
            data_q[i] <= '0;
            we_q[i]   <= 1'b0;
            cnt_q[i]  <= '0;
            cmt_q[i]  <= 1'b0;
            kill_q[i] <= 1'b0;
         end
      end else begin
         // Free slots may also age or get marked; a push rewrites every field anyway
         for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
            if (commit_valid_i && commit_id_i == id_q[i]) begin
               if (commit_kill_i) kill_q[i] <= 1'b1;
               else               cmt_q[i]  <= 1'b1;
            end
         end
         if (push) begin
            id_q[tail_q]   <= issue_id_i;
            rd_q[tail_q]   <= issue_instr_i[11:7];
            data_q[tail_q] <= dec_result;
            we_q[tail_q]   <= dec_wb;
            cnt_q[tail_q]  <= dec_cnt;
            // A commit for this id in the same cycle lands on the new entry
            cmt_q[tail_q]  <= commit_valid_i & (commit_id_i == issue_id_i) & ~commit_kill_i;
            kill_q[tail_q] <= commit_valid_i & (commit_id_i == issue_id_i) &  commit_kill_i;
         end
      end
   end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// tb/tb_cvxif_copro_responder.sv - directed table-driven bench for cvxif_copro_responder
module tb_cvxif_copro_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_ready, issue_accept, issue_wb;
   logic [31:0] issue_instr;
   logic [2:0]  issue_id;
   logic [63:0] rs1, rs2;
   logic        commit_valid, commit_kill;
   logic [2:0]  commit_id;
   logic        result_valid, result_ready, result_we;
   logic [2:0]  result_id;
   logic [4:0]  result_rd;
   logic [63:0] result_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cvxif_copro_responder dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .issue_instr_i(issue_instr), .issue_id_i(issue_id),
      .issue_rs1_i(rs1), .issue_rs2_i(rs2),
      .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_id_o(result_id), .result_rd_o(result_rd),
      .result_data_o(result_data), .result_we_o(result_we)
   );

   typedef struct {
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [6:0]  opc;
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  id;
      logic [4:0]  rd;
      logic        acc;
      logic        wb;
      logic [63:0] data;
      logic        we;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
      return {f7, 10'd0, f3, rd, opc};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_issue(input logic [2:0] f3, input logic [2:0] id, input logic [4:0] rd,
                              input logic [63:0] a, input logic [63:0] b);
      issue_valid = 1'b1;
      issue_instr = mk(7'd0, f3, rd, 7'b0001011);
      issue_id    = id;
      rs1         = a;
      rs2         = b;
   endtask

   initial begin
      int   lat, beats;
      logic got, seen;
      logic [2:0]  first_id;
      logic [4:0]  first_rd;
      logic [63:0] first_data;

      //       f7    f3      opc          a                      b        id    rd     acc  wb   data                   we  lat
      vecs[0] = '{7'd0, 3'b000, 7'b0001011, 64'd5,                 64'd7,      3'd2, 5'd3,  1, 1, 64'd12,                1, 1};
      vecs[1] = '{7'd0, 3'b001, 7'b0001011, 64'hF0F0,              64'h0FF0,   3'd4, 5'd10, 1, 1, 64'hFF00,              1, 1};
      vecs[2] = '{7'd0, 3'b000, 7'b0001011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,    3'd7, 5'd31, 1, 1, 64'd1,                 1, 1};
      vecs[3] = '{7'd0, 3'b011, 7'b0001011, 64'd123,               64'd9,      3'd1, 5'd5,  1, 0, 64'd0,                 0, 1};
      vecs[4] = '{7'd0, 3'b111, 7'b0001011, 64'd1,                 64'd1,      3'd3, 5'd1,  0, 0, 64'd0,                 0, 0};
      vecs[5] = '{7'd1, 3'b000, 7'b0001011, 64'd1,                 64'd1,      3'd3, 5'd1,  0, 0, 64'd0,                 0, 0};
      vecs[6] = '{7'd0, 3'b000, 7'b0101011, 64'd1,                 64'd1,      3'd3, 5'd1,  0, 0, 64'd0,                 0, 0};
`ifdef CVXIF_COPRO_MUL_EN
      vecs[7] = '{7'd0, 3'b010, 7'b0001011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,    3'd5, 5'd7,  1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 3};
      vecs[8] = '{7'd0, 3'b010, 7'b0001011, 64'd3,                 64'd5,      3'd6, 5'd8,  1, 1, 64'd15,                1, 3};
`else
      vecs[7] = '{7'd0, 3'b010, 7'b0001011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,    3'd5, 5'd7,  0, 0, 64'd0,                 0, 0};
      vecs[8] = '{7'd0, 3'b010, 7'b0001011, 64'd3,                 64'd5,      3'd6, 5'd8,  0, 0, 64'd0,                 0, 0};
`endif

      rst = 1'b1;
      issue_valid = 1'b0; issue_instr = '0; issue_id = '0; rs1 = '0; rs2 = '0;
      commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", result_valid, 0);
      chk("rst_data", result_data, 0);
      chk("rst_id", result_id, 0);
      chk("rst_ready", issue_ready, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", result_valid, 0);
      chk("post_rst_accept", issue_accept, 0);

      // table: issue with commit in the same cycle, then collect result
      for (int v = 0; v < 9; v++) begin
         @(posedge clk); #1;
         issue_valid = 1'b1;
         issue_instr = mk(vecs[v].f7, vecs[v].f3, vecs[v].rd, vecs[v].opc);
         issue_id = vecs[v].id; rs1 = vecs[v].a; rs2 = vecs[v].b;
         commit_valid = 1'b1; commit_id = vecs[v].id; commit_kill = 1'b0;
         result_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_ready", v), issue_ready, 1);
         chk($sformatf("v%0d_accept", v), issue_accept, vecs[v].acc);
         chk($sformatf("v%0d_wb", v), issue_wb, vecs[v].wb);
         @(posedge clk); #1;
         issue_valid = 1'b0; commit_valid = 1'b0;
         if (vecs[v].acc) begin
            got = 1'b0; lat = 0;
            for (int c = 1; c <= 10 && !got; c++) begin
               @(negedge clk);
               if (result_valid) begin
                  got = 1'b1; lat = c;
                  chk($sformatf("v%0d_id", v), result_id, vecs[v].id);
                  chk($sformatf("v%0d_rd", v), result_rd, vecs[v].rd);
                  chk($sformatf("v%0d_data", v), result_data, vecs[v].data);
                  chk($sformatf("v%0d_we", v), result_we, vecs[v].we);
               end
            end
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
         end else begin
            seen = 1'b0;
            repeat (5) begin
               @(negedge clk);
               if (result_valid) seen = 1'b1;
            end
            chk($sformatf("v%0d_no_result", v), seen, 0);
            chk($sformatf("v%0d_ready_after", v), issue_ready, 1);
         end
      end

      // fill queue without commit, then backpressure and drain in order
      result_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive_issue(3'b000, 3'(i), 5'(i + 8), 64'(i), 64'd10);
         @(negedge clk);
         chk($sformatf("fill%0d_accept", i), issue_accept, 1);
      end
      @(posedge clk); #1;
      drive_issue(3'b000, 3'd7, 5'd1, 64'd1, 64'd1);
      @(negedge clk);
      chk("full_ready", issue_ready, 0);
      chk("full_accept", issue_accept, 0);
      chk("full_no_valid", result_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         issue_valid = 1'b0;
         commit_valid = 1'b1; commit_id = 3'(i); commit_kill = 1'b0;
      end
      @(posedge clk); #1 commit_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_valid", k), result_valid, 1);
         chk($sformatf("hold%0d_id", k), result_id, 0);
         chk($sformatf("hold%0d_rd", k), result_rd, 8);
         chk($sformatf("hold%0d_data", k), result_data, 10);
      end
      @(posedge clk); #1 result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("full_ready_on_pop", issue_ready, 0);
         chk($sformatf("drain%0d_valid", i), result_valid, 1);
         chk($sformatf("drain%0d_id", i), result_id, 3'(i));
         chk($sformatf("drain%0d_data", i), result_data, 64'(10 + i));
      end
      @(negedge clk);
      chk("drain_empty", result_valid, 0);
      chk("drain_ready", issue_ready, 1);

      // kill the older op, commit the younger one
      @(posedge clk); #1 drive_issue(3'b000, 3'd1, 5'd1, 64'd1, 64'd1);
      @(posedge clk); #1 drive_issue(3'b001, 3'd2, 5'd2, 64'd6, 64'd3);
      @(posedge clk); #1;
      issue_valid = 1'b0;
      commit_valid = 1'b1; commit_id = 3'd1; commit_kill = 1'b1;
      @(posedge clk); #1 commit_id = 3'd2; commit_kill = 1'b0;
      @(posedge clk); #1 commit_valid = 1'b0;
      beats = 0; first_id = '0; first_rd = '0; first_data = '0;
      repeat (10) begin
         @(negedge clk);
         if (result_valid) begin
            if (beats == 0) begin
               first_id = result_id; first_rd = result_rd; first_data = result_data;
            end
            beats++;
         end
      end
      chk("kill_beats", beats, 1);
      chk("kill_id", first_id, 2);
      chk("kill_rd", first_rd, 2);
      chk("kill_data", first_data, 5);

      // asynchronous reset with queued ops and a valid result
      result_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive_issue(3'b000, 3'(i + 4), 5'(i + 20), 64'(100 + i), 64'd0);
         commit_valid = 1'b1; commit_id = 3'(i + 4); commit_kill = 1'b0;
      end
      @(posedge clk); #1 issue_valid = 1'b0; commit_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", result_valid, 1);
      chk("pre_rst_data", result_data, 100);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", result_valid, 0);
      chk("mid_rst_data", result_data, 0);
      chk("mid_rst_rd", result_rd, 0);
      chk("mid_rst_we", result_we, 0);
      chk("mid_rst_ready", issue_ready, 1);
      @(posedge clk); #1 rst = 1'b0; result_ready = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (result_valid) seen = 1'b1;
      end
      chk("post_rst_stale", seen, 0);
      chk("post_rst_issue_ready", issue_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
